// File: rtl/multicycle_pkg.sv
// multicycle_pkg: opcode and FSM state enums plus instruction field positions
package multicycle_pkg;
  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_LOAD  = 3'd4,
    OP_STORE = 3'd5,
    OP_BEQ   = 3'd6,
    OP_HALT  = 3'd7
  } op_t;
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_HALT
  } state_t;
  localparam int OP_HI  = 31;
  localparam int OP_LO  = 29;
  localparam int RD_LO  = 24;
  localparam int RS1_LO = 19;
  localparam int RS2_LO = 14;
  localparam int IMM_HI = 13;
  localparam int IMM_LO = 0;
endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational ALU producing the op result and an operand-equality flag
module mc_alu
  import multicycle_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              eq
);
  always_comb begin
    result = op == OP_SUB ? a - b :
             op == OP_AND ? a & b :
             op == OP_OR  ? a | b : a + b;
    eq = a == b;
  end
endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: 8-opcode multicycle CPU with req/ack instruction and data ports
// Define MULTICYCLE_CORE_PERF_EN to add the retired_cnt instruction counter output.
module multicycle_core
  import multicycle_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef MULTICYCLE_CORE_PERF_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);
  localparam int RW = $clog2(NREGS);
  state_t            r_state, w_next;
  logic [31:0]       r_ir;
  logic [ADDR_W-1:0] r_pc, r_dmem_addr;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_a, r_b, r_res, r_dmem_wdata;
  logic              r_imem_req, r_dmem_req, r_dmem_we, r_halted;
  op_t               w_op;
  logic [RW-1:0]     w_rd, w_rs1, w_rs2;
  logic [ADDR_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu;
  logic              w_eq;

  assign w_op  = op_t'(r_ir[OP_HI:OP_LO]);
  assign w_rd  = r_ir[RD_LO +: RW];
  assign w_rs1 = r_ir[RS1_LO +: RW];
  assign w_rs2 = r_ir[RS2_LO +: RW];
  assign w_imm = ADDR_W'(r_ir[IMM_HI:IMM_LO]);

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign halted     = r_halted;

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op(w_op),
    .a(r_a),
    .b(r_b),
    .result(w_alu),
    .eq(w_eq)
  );

  always_ff @(posedge clk)
    r_state <= rst ? S_FETCH : w_next;

  // acks only count while the matching request is actually raised
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     w_next = imem_ack && r_imem_req ? S_DECODE : S_FETCH;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = w_op == OP_HALT ? S_HALT :
                            w_op == OP_BEQ  ? S_FETCH :
                            (w_op == OP_LOAD || w_op == OP_STORE) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY:    w_next = !(dmem_ack && r_dmem_req) ? S_MEMORY :
                            w_op == OP_LOAD ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: w_next = S_FETCH;
      default:     w_next = S_HALT;
    endcase
  end

  // request flops follow the next state so they are high exactly while in FETCH/MEMORY
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= '0;
      r_ir         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_imem_req   <= 1'b1;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_halted     <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_imem_req <= w_next == S_FETCH;
      r_dmem_req <= w_next == S_MEMORY;
      r_dmem_we  <= w_next == S_MEMORY && w_op == OP_STORE;
      r_halted   <= w_next == S_HALT;
      if (r_state == S_FETCH && r_imem_req && imem_ack) begin
        r_ir <= imem_rdata;
        r_pc <= r_pc + 1'b1;
      end
      if (r_state == S_DECODE) begin
        r_a <= r_regs[w_rs1];
        r_b <= r_regs[w_rs2];
      end
      if (r_state == S_EXECUTE) begin
        r_res        <= w_alu;
        r_dmem_addr  <= ADDR_W'(r_a) + w_imm;
        r_dmem_wdata <= r_b;
        if (w_op == OP_BEQ && w_eq) r_pc <= w_imm;
      end
      if (r_state == S_MEMORY && r_dmem_req && dmem_ack && w_op == OP_LOAD) r_res <= dmem_rdata;
      if (r_state == S_WRITEBACK && w_rd != '0) r_regs[w_rd] <= r_res;
    end
  end

`ifdef MULTICYCLE_CORE_PERF_EN
  logic [31:0] r_retired;
  assign retired_cnt = r_retired;
  always_ff @(posedge clk) begin
    if (rst) r_retired <= '0;
    else if (r_state != S_FETCH && w_next == S_FETCH) r_retired <= r_retired + 1'b1;
  end
`endif
endmodule
